// File: rtl/hammu_hamnhan_core.sv
// rtl/hammu_hamnhan_core.sv - iterative shift-add multiply / exponent engine.
// Define HAMMU_EXP_EN to compile in exponent mode (sel_in=1); otherwise every start multiplies.
module hammu_hamnhan_core #(
  parameter int DATA_W = 16,
  parameter int P_W    = 32
) (
  input  logic              S_AXI_ACLK,
  input  logic              S_AXI_ARESET,
  input  logic [DATA_W-1:0] a_in,
  input  logic [DATA_W-1:0] b_in,
  input  logic              sel_in,
  input  logic              start,
  output logic [P_W-1:0]    p_out,
  output logic              done,
  output logic              busy,
  output logic              ovf
);

  localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  typedef enum logic [1:0] {IDLE, MUL, ACC} state_t;

  state_t            state_q, state_d;
  logic [P_W-1:0]    acc_q, acc_d;
  logic [P_W-1:0]    mcand_q, mcand_d;
  logic [P_W-1:0]    p_q, p_d;
  logic [DATA_W-1:0] mplr_q, mplr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              done_q, done_d;
  logic              busy_q, busy_d;
  logic              ovf_q, ovf_d;
  logic [P_W:0]      sum;

`ifdef HAMMU_EXP_EN
  logic [DATA_W-1:0] base_q, base_d;
  logic [DATA_W-1:0] iter_q, iter_d;
`else
  logic unused_sel;
  assign unused_sel = sel_in;
`endif

  assign sum = {1'b0, acc_q} + {1'b0, mcand_q};

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    mcand_d = mcand_q;
    mplr_d  = mplr_q;
    cnt_d   = cnt_q;
    p_d     = p_q;
    done_d  = done_q;
    busy_d  = busy_q;
    ovf_d   = ovf_q;
`ifdef HAMMU_EXP_EN
    base_d  = base_q;
    iter_d  = iter_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          done_d  = 1'b0;
          ovf_d   = 1'b0;
          busy_d  = 1'b1;
          acc_d   = '0;
          mcand_d = P_W'(a_in);
          mplr_d  = b_in;
          cnt_d   = '0;
          state_d = MUL;
`ifdef HAMMU_EXP_EN
          base_d  = a_in;
          iter_d  = DATA_W'(1);
          if (sel_in) begin
            // A^0 completes on the start edge without entering the datapath.
            if (b_in == '0) begin
              p_d     = P_W'(1);
              done_d  = 1'b1;
              busy_d  = 1'b0;
              state_d = IDLE;
            end else begin
              iter_d = b_in;
              mplr_d = DATA_W'(1);
            end
          end
`endif
        end
      end

      MUL: begin
        if (mplr_q[0]) begin
          acc_d = sum[P_W-1:0];
          if (sum[P_W]) ovf_d = 1'b1;
        end
        if (mcand_q[P_W-1] && (mplr_q[DATA_W-1:1] != '0)) ovf_d = 1'b1;
        mcand_d = mcand_q << 1;
        mplr_d  = mplr_q >> 1;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(DATA_W - 1)) state_d = ACC;
      end

      ACC: begin
`ifdef HAMMU_EXP_EN
        // Another power step: feed the truncated partial result back as multiplier.
        if (iter_q != DATA_W'(1)) begin
          iter_d  = iter_q - 1'b1;
          acc_d   = '0;
          mcand_d = P_W'(base_q);
          mplr_d  = acc_q[DATA_W-1:0];
          cnt_d   = '0;
          if ((acc_q >> DATA_W) != '0) ovf_d = 1'b1;
          state_d = MUL;
        end else
`endif
        begin
          p_d     = acc_q;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
    if (S_AXI_ARESET) begin
      state_q <= IDLE;
      acc_q   <= '0;
      mcand_q <= '0;
      mplr_q  <= '0;
      cnt_q   <= '0;
      p_q     <= '0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
      ovf_q   <= 1'b0;
`ifdef HAMMU_EXP_EN
      base_q  <= '0;
      iter_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      mcand_q <= mcand_d;
      mplr_q  <= mplr_d;
      cnt_q   <= cnt_d;
      p_q     <= p_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
      ovf_q   <= ovf_d;
`ifdef HAMMU_EXP_EN
      base_q  <= base_d;
      iter_q  <= iter_d;
`endif
    end
  end

  assign p_out = p_q;
  assign done  = done_q;
  assign busy  = busy_q;
  assign ovf   = ovf_q;

endmodule

// File: tb/tb_hammu_hamnhan_core.sv
// tb/tb_hammu_hamnhan_core.sv - randomized scoreboard bench for hammu_hamnhan_core.
// Expected results come from a plain-arithmetic model; a negedge monitor pops and compares.
module tb_hammu_hamnhan_core;
  localparam int DW = 16;
  localparam int PW = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [DW-1:0] a_in = '0;
  logic [DW-1:0] b_in = '0;
  logic          sel_in = 1'b0;
  logic          start = 1'b0;
  logic [PW-1:0] p_out;
  logic          done, busy, ovf;

  hammu_hamnhan_core #(.DATA_W(DW), .P_W(PW)) dut (
    .S_AXI_ACLK  (clk),
    .S_AXI_ARESET(rst),
    .a_in        (a_in),
    .b_in        (b_in),
    .sel_in      (sel_in),
    .start       (start),
    .p_out       (p_out),
    .done        (done),
    .busy        (busy),
    .ovf         (ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [PW-1:0] p;
    logic          o;
    int            start_edge;
    int            lat;
  } exp_t;

  exp_t          sb_q[$];
  int            checks = 0;
  int            fails = 0;
  int            cyc = 0;
  logic [PW-1:0] last_p = '0;
  logic          busy_prev = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, expv, $time);
    end
  endfunction

  // Latency is counted in rising edges after the edge that sampled start.
  function automatic void model(input logic [DW-1:0] a, input logic [DW-1:0] b, input logic sel,
                                output logic [PW-1:0] p, output logic o, output int lat);
    longint unsigned r, prod;
    logic use_exp;
`ifdef HAMMU_EXP_EN
    use_exp = sel;
`else
    use_exp = sel & 1'b0;
`endif
    o = 1'b0;
    if (!use_exp) begin
      prod = longint'(a) * longint'(b);
      p    = prod[PW-1:0];
      o    = (prod >> PW) != 0;
      lat  = DW + 1;
    end else if (b == '0) begin
      p   = PW'(1);
      lat = 0;
    end else begin
      r = 1;
      for (int i = 1; i <= int'(b); i++) begin
        prod = longint'(a) * (r % (64'd1 << DW));
        if ((prod >> PW) != 0) o = 1'b1;
        r = prod % (64'd1 << PW);
        if (i < int'(b) && r >= (64'd1 << DW)) o = 1'b1;
      end
      p   = r[PW-1:0];
      lat = (DW + 1) * int'(b);
    end
  endfunction

  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst) begin
      busy_prev = 1'b0;
    end else begin
      check("busy_done_exclusive", {63'd0, busy & done}, 64'd0);
      if (!done) check("p_out_hold", p_out, last_p);
      if (done && sb_q.size() > 0 && cyc >= sb_q[0].start_edge) begin
        e = sb_q.pop_front();
        check("p_out", p_out, e.p);
        check("ovf", ovf, e.o);
        check("latency", cyc - e.start_edge, e.lat);
        check("busy_at_done", busy, 1'b0);
        if (e.lat > 0) check("busy_before_done", busy_prev, 1'b1);
        last_p = e.p;
      end
      busy_prev = busy;
    end
  end

  task automatic issue(input logic [DW-1:0] a, input logic [DW-1:0] b, input logic sel);
    exp_t e;
    model(a, b, sel, e.p, e.o, e.lat);
    e.start_edge = cyc + 1;
    a_in   = a;
    b_in   = b;
    sel_in = sel;
    start  = 1'b1;
    sb_q.push_back(e);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int bound);
    for (int n = 0; n < bound && sb_q.size() != 0; n++) @(negedge clk);
    checks++;
    if (sb_q.size() != 0) begin
      fails++;
      $display("FAIL completion_timeout: got pending=%0d required pending=0", sb_q.size());
      sb_q.delete();
    end
  endtask

  task automatic run(input logic [DW-1:0] a, input logic [DW-1:0] b, input logic sel);
    issue(a, b, sel);
    wait_done((sel ? (DW + 1) * (int'(b) + 1) : DW + 1) + 20);
  endtask

  initial begin
    logic [PW-1:0] ep;
    logic          eo;
    int            el;
    logic [DW-1:0] ra, rb;
    logic          rs;

    repeat (2) @(negedge clk);
    check("reset_p_out", p_out, 0);
    check("reset_done", done, 0);
    check("reset_busy", busy, 0);
    check("reset_ovf", ovf, 0);
    rst = 1'b0;
    @(negedge clk);

    run(16'd2, 16'd3, 1'b0);
    run(16'd2, 16'd3, 1'b1);
    run(16'd7, 16'd0, 1'b1);
    run(16'hFFFF, 16'hFFFF, 1'b0);
    run(16'd2, 16'd32, 1'b1);
    run(16'd0, 16'hFFFF, 1'b0);
    run(16'hFFFF, 16'd1, 1'b1);
    run(16'd256, 16'd2, 1'b1);
    run(16'd256, 16'd3, 1'b1);
    run(16'd0, 16'd0, 1'b1);

    // A second start during a run must be ignored entirely.
    model(16'd5, 16'd7, 1'b0, ep, eo, el);
    issue(16'd5, 16'd7, 1'b0);
    repeat (4) @(negedge clk);
    a_in = 16'd9; b_in = 16'd9; sel_in = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(60);
    repeat (10) @(negedge clk);
    check("extra_start_done", done, 1'b1);
    check("extra_start_busy", busy, 1'b0);
    check("extra_start_p_out", p_out, ep);

    for (int k = 0; k < 40; k++) begin
      rs = 1'($urandom_range(0, 1));
      if (rs) begin
        rb = DW'($urandom_range(0, 5));
        ra = ($urandom_range(0, 1) != 0) ? DW'($urandom_range(0, 20)) : DW'($urandom);
      end else begin
        ra = DW'($urandom);
        rb = DW'($urandom);
      end
      run(ra, rb, rs);
    end

    // Asynchronous reset part-way through a run.
    issue(16'd123, 16'd456, 1'b0);
    repeat (5) @(negedge clk);
    #2;
    rst = 1'b1;
    last_p = '0;
    sb_q.delete();
    #1;
    check("midrun_reset_p_out", p_out, 0);
    check("midrun_reset_done", done, 0);
    check("midrun_reset_busy", busy, 0);
    check("midrun_reset_ovf", ovf, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("post_reset_idle_busy", busy, 0);
    run(16'd11, 16'd13, 1'b0);
    run(16'd3, 16'd4, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
